// File: rtl/counter_n_en_pkg.sv
// rtl/counter_n_en_pkg.sv - shared helpers for the modulo-N enabled counter
package counter_n_en_pkg;

  // True when ulimit is a usable modulus for a counter of the given width.
  function automatic bit ulimit_legal(input int ulimit, input int width);
    longint span;
    span = longint'(1) << width;
    return (ulimit >= 2) && (longint'(ulimit) <= span);
  endfunction

endpackage

// File: rtl/counter_n_en.sv
// rtl/counter_n_en.sv - modulo-ULIMIT up-counter with enable, sync clear and terminal count
module counter_n_en
  import counter_n_en_pkg::*;
#(
  parameter int ULIMIT = 10,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sclr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  // Stop elaboration on a modulus the count register cannot represent.
  if (!ulimit_legal(ULIMIT, WIDTH)) begin : g_bad_ulimit
    $fatal(1, "counter_n_en: ULIMIT=%0d illegal for WIDTH=%0d (need 2..2^WIDTH)", ULIMIT, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(ULIMIT - 1);

  logic [WIDTH-1:0] cnt;

  // Count register: clear beats enable; >= LAST also folds upset states back to 0.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_sclr) begin
      cnt <= '0;
    end else if (i_en) begin
      if (cnt >= LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  assign o_cnt = cnt;

  // Terminal count ignores i_sclr so a cascaded parent sees the carry it expects.
  always_comb begin
    o_tc = i_en && (cnt == LAST);
  end

endmodule

// File: tb/tb_counter_n_en.sv
// tb/tb_counter_n_en.sv - self-checking bench for counter_n_en across several moduli
module tb_counter_n_en;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclr = 1'b0;
  logic en = 1'b0;

  logic [3:0] cnt10;
  logic       tc10;
  logic [0:0] cnt2;
  logic       tc2;
  logic [3:0] cnt16;
  logic       tc16;
  logic [9:0] cnt800;
  logic       tc800;

  int total = 0;
  int bad = 0;
  bit compare_on = 1'b0;

  int m10 = 0;
  int m2 = 0;
  int m16 = 0;
  int m800 = 0;

  always #5 clk = ~clk;

  counter_n_en #(.ULIMIT(10), .WIDTH(4)) u10 (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .o_cnt(cnt10), .o_tc(tc10));
  counter_n_en #(.ULIMIT(2), .WIDTH(1)) u2 (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .o_cnt(cnt2), .o_tc(tc2));
  counter_n_en #(.ULIMIT(16), .WIDTH(4)) u16 (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .o_cnt(cnt16), .o_tc(tc16));
  counter_n_en #(.ULIMIT(800), .WIDTH(10)) u800 (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .o_cnt(cnt800), .o_tc(tc800));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Position in the counting sequence after one edge.
  function automatic int next_pos(input int m, input int u, input logic c, input logic e);
    if (c) return 0;
    if (e) return (m + 1) % u;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m10 = 0; m2 = 0; m16 = 0; m800 = 0;
    end else begin
      m10  = next_pos(m10, 10, sclr, en);
      m2   = next_pos(m2, 2, sclr, en);
      m16  = next_pos(m16, 16, sclr, en);
      m800 = next_pos(m800, 800, sclr, en);
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      check("model_cnt10", int'(cnt10), m10);
      check("model_tc10", int'(tc10), int'(en && m10 == 9));
      check("model_cnt2", int'(cnt2), m2);
      check("model_tc2", int'(tc2), int'(en && m2 == 1));
      check("model_cnt16", int'(cnt16), m16);
      check("model_tc16", int'(tc16), int'(en && m16 == 15));
      check("model_cnt800", int'(cnt800), m800);
      check("model_tc800", int'(tc800), int'(en && m800 == 799));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    sclr = 1'b1; en = 1'b0;
    tick();
    sclr = 1'b0;
  endtask

  task automatic run_en(input int n);
    en = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_seq[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

  initial begin
    #2;
    check("reset_cnt10", int'(cnt10), 0);
    check("reset_tc10", int'(tc10), 0);
    tick();
    rst_n = 1'b1;
    compare_on = 1'b1;
    tick();
    check("hold_after_reset", int'(cnt10), 0);

    // Asynchronous reset mid-count at 5.
    clear_all();
    run_en(5);
    check("pre_reset_cnt5", int'(cnt10), 5);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_cnt", int'(cnt10), 0);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    check("post_release_hold1", int'(cnt10), 0);
    tick();
    check("post_release_hold2", int'(cnt10), 0);

    // Clear for one edge, then an idle edge.
    run_en(3);
    en = 1'b0;
    sclr = 1'b1;
    tick();
    check("clear_edge1", int'(cnt10), 0);
    sclr = 1'b0;
    tick();
    check("clear_edge2", int'(cnt10), 0);

    // Count and wrap over 11 enabled edges.
    en = 1'b1;
    #1;
    check("tc_at_zero", int'(tc10), 0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("wrap_cnt10", int'(cnt10), exp_seq[i]);
      check("wrap_tc10", int'(tc10), int'(exp_seq[i] == 9));
    end
    en = 1'b0;
    #1;
    check("tc_low_no_en", int'(tc10), 0);

    // Pseudo-random enable gating, scored by the model.
    for (int i = 0; i < 50; i++) begin
      en = logic'($urandom_range(0, 1));
      tick();
    end

    // Clear beats terminal count and a mid-count value.
    clear_all();
    run_en(9);
    check("prio_at9", int'(cnt10), 9);
    check("prio_tc_at9", int'(tc10), 1);
    sclr = 1'b1;
    #1;
    check("tc_with_sclr", int'(tc10), 1);
    tick();
    check("prio_clear_at9", int'(cnt10), 0);
    sclr = 1'b0;
    run_en(4);
    check("prio_at4", int'(cnt10), 4);
    sclr = 1'b1;
    tick();
    check("prio_clear_at4", int'(cnt10), 0);
    sclr = 1'b0;

    // Parameter sweep.
    clear_all();
    check("u2_start", int'(cnt2), 0);
    run_en(1);
    check("u2_one", int'(cnt2), 1);
    check("u2_tc", int'(tc2), 1);
    run_en(1);
    check("u2_wrap", int'(cnt2), 0);

    clear_all();
    run_en(15);
    check("u16_at15", int'(cnt16), 15);
    check("u16_tc15", int'(tc16), 1);
    run_en(1);
    check("u16_wrap", int'(cnt16), 0);
    check("u16_tc0", int'(tc16), 0);

    clear_all();
    run_en(799);
    check("u800_at799", int'(cnt800), 799);
    check("u800_tc799", int'(tc800), 1);
    run_en(1);
    check("u800_wrap", int'(cnt800), 0);
    check("u800_cnt10_mod", int'(cnt10), 0);
    en = 1'b0;
    tick();
    compare_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
